fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the PC, issues read requests to the instruction cache, and captures returned words into the IF/ID latch. The decode-side control unit reads its instruction word from that latch. It handles the stall, flush, redirect (branch/jump) and halt events that the downstream stages feed back.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- imemREN  out  1  instruction-cache read enable.
- imemaddr  out  32  fetch address (word_t); always equals current PC.
- ihit  in  1  cache has valid data for imemaddr this cycle.
- imemload  in  32  instruction word returned by the cache.
- stall  in  1  decode cannot accept a new instruction; hold PC and latch.
- flush  in  1  invalidate the IF/ID latch.
- redirect  in  1  load redirect_pc as the next fetch address.
- redirect_pc  in  32  branch/jump target.
- halt  in  1  halt decoded downstream; stop fetching.
- if_instr  out  32  latched instruction (word_t) to decode.
- if_npc  out  32  latched PC+4 of if_instr.
- if_valid  out  1  if_instr holds a real instruction.

## Operation
- States: FETCH, DRAIN, HALTED (fetch_state_t).
- Cycle 0 out of reset: state=FETCH, pc=PC_INIT, imemREN=1.

In FETCH:
- ihit & !stall & !redirect: latch if_instr=imemload, if_npc=pc+4, if_valid=1, and set pc<=pc+4.
- ihit & stall & !redirect: pc and latch unchanged; imemREN stays 1.
- redirect & ihit: the fetched word is dropped. pc<=redirect_pc, latch cleared, state stays FETCH.
- redirect & !ihit: imemaddr is held stable and the request is not abandoned. The target is stored in pend_pc, latch cleared, state<=DRAIN.

In DRAIN:
- imemREN=1 and imemaddr=old pc.
- A further redirect overwrites pend_pc.
- On ihit the word is discarded, pc<=pend_pc (or redirect_pc if redirect is also asserted that cycle), latch stays cleared, and state<=FETCH.

Halt:
- halt in FETCH or DRAIN: state<=HALTED, imemREN<=0, latch cleared.
- HALTED is sticky until RST; redirect, stall and ihit are ignored.

Priorities and arithmetic:
- Priority is RST > halt > redirect > flush > stall > normal advance.
- flush & stall in the same cycle: latch cleared, pc held.
- A cleared latch means if_instr=32'h0 (sll $0 nop), if_npc=0, if_valid=0.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC advances to 0.
- redirect_pc[1:0] is forced to 2'b00 before loading.

## Timing
Reset values:
- pc=PC_INIT, state=FETCH, pend_pc=0.
- if_instr=0, if_npc=0, if_valid=0.
- imemREN=0 during the reset cycle and 1 on the first cycle after.

Latency and hold rules:
- Fetch to decode latency is 1 edge after ihit.
- A 1-cycle hit stream sustains 1 instruction per cycle.
- Redirect takes effect on the next edge. The first target fetch is presented the cycle after redirect, or the cycle after the draining ihit.
- imemaddr never changes while imemREN=1 and ihit=0 (cache handshake rule).
- RST asserted mid-DRAIN aborts the pending redirect: pend_pc is discarded and pc=PC_INIT.

## Structure
- Shared package fetch_pkg holds fetch_state_t (FETCH, DRAIN, HALTED) and the NOP_INSTR constant (32'h0).
- word_t is taken from cpu_types_pkg.
- One sub-module, if_id_latch: the IF/ID register with load, clear and hold controls, reused by later pipeline registers.
- The FSM and PC logic live in fetch_stage.

## Test plan
- Reset then 4 consecutive 1-cycle hits from PC_INIT=0 -> if_npc=4,8,12,16 on successive cycles; if_valid=1 from cycle 2.
- Miss (ihit=0 for 3 cycles) at pc=0x40 -> imemaddr stays 0x40, if_valid=0, then the word latches with if_npc=0x44.
- Redirect to 0x103 asserted during a miss at 0x20, then ihit -> returned word discarded, next imemaddr=0x100, if_valid=0 throughout.
- redirect, flush and stall together with ihit at pc=0x10, redirect_pc=0x200 -> pc=0x200, latch cleared; stall alone for 2 cycles -> pc and latch unchanged.
- pc=0xFFFF_FFFC with a hit -> pc wraps to 0, if_npc=0.
- halt at pc=0x30 -> imemREN=0 next cycle; a later redirect leaves pc=0x30 frozen; RST returns pc to PC_INIT.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Core-wide scalar types shared by every pipeline stage.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

// File: rtl/fetch_pkg.sv
// Types and constants for the instruction-fetch stage.
package fetch_pkg;
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // sll $0,$0,0 doubles as the bubble left in a cleared pipeline register
    localparam word_t NOP_INSTR = 32'h0000_0000;

    function automatic word_t align_word(input word_t addr);
        return addr & 32'hFFFF_FFFC;
    endfunction
endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: clear beats load, and neither means hold.
module if_id_latch
    import cpu_types_pkg::*;
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  clear,
    input  word_t next_instr,
    input  word_t next_npc,
    output word_t instr,
    output word_t npc,
    output logic  valid
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            instr <= NOP_INSTR;
            npc   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= next_instr;
            npc   <= next_npc;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, talks to the I-cache and fills the IF/ID latch.
module fetch_stage
    import cpu_types_pkg::*;
    import fetch_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  RST,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  stall,
    input  logic  flush,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    output word_t if_instr,
    output word_t if_npc,
    output logic  if_valid
);

    fetch_state_t state;
    word_t        pc;
    word_t        pend_pc;
    word_t        target;
    word_t        pc_plus4;
    logic         latch_load;
    logic         latch_clear;

    assign target   = align_word(redirect_pc);
    assign pc_plus4 = pc + 32'd4;
    assign imemaddr = pc;
    assign imemREN  = !RST && (state != HALTED);

    // A miss without stall leaves a bubble for decode rather than a stale word
    always_comb begin
        latch_load  = 1'b0;
        latch_clear = 1'b0;
        case (state)
            FETCH: begin
                if (halt || redirect || flush)
                    latch_clear = 1'b1;
                else if (!stall) begin
                    if (ihit)
                        latch_load = 1'b1;
                    else
                        latch_clear = 1'b1;
                end
            end
            default: latch_clear = 1'b1;
        endcase
    end

    // During DRAIN the PC stays on the outstanding request until the cache answers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FETCH;
            pc      <= PC_INIT;
            pend_pc <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (halt)
                        state <= HALTED;
                    else if (redirect) begin
                        if (ihit)
                            pc <= target;
                        else begin
                            pend_pc <= target;
                            state   <= DRAIN;
                        end
                    end else if (!flush && !stall && ihit)
                        pc <= pc_plus4;
                end
                DRAIN: begin
                    if (halt)
                        state <= HALTED;
                    else if (ihit) begin
                        pc    <= redirect ? target : pend_pc;
                        state <= FETCH;
                    end else if (redirect)
                        pend_pc <= target;
                end
                HALTED: state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

    if_id_latch u_if_id (
        .clk        (CLK),
        .rst        (RST),
        .load       (latch_load),
        .clear      (latch_clear),
        .next_instr (imemload),
        .next_npc   (pc_plus4),
        .instr      (if_instr),
        .npc        (if_npc),
        .valid      (if_valid)
    );

endmodule
